// File: rtl/io_mmtx_pkt.sv
// io_mmtx_pkt: store-and-forward packet buffer for the IO channel TX path.
// Framed words are staged once, written into an inferred dual-port RAM behind a
// speculative write pointer, and released to the reader only once the whole
// packet has been committed. Over-length, aborted and no-space packets are
// dropped whole. One header word per packet can carry a 16-bit sequence tick.
//
// Ports:
//   clk_12_5m, rst_12_5m      : clock, asynchronous active-high reset
//   wr_sel, wr_dval, wr_sop,
//   wr_eop, wr_data           : framed write port (ignored while wr_sel = 0)
//   rd_req                    : read request level, one word per cycle
//   rd_dval, rd_sop, rd_eop,
//   rd_data                   : read port, 1 cycle after the RAM read
//   pkt_avail, pkt_cnt        : committed-packet status
//   drop_cnt                  : saturating dropped-packet count
module io_mmtx_pkt #(
   parameter int unsigned DW       = 16,
   parameter int unsigned AW       = 10,
   parameter int unsigned MAX_PKT  = 256,
   parameter int unsigned TICK_EN  = 1,
   parameter int unsigned TICK_POS = 1
) (
   input  logic          clk_12_5m,
   input  logic          rst_12_5m,
   input  logic          wr_sel,
   input  logic          wr_dval,
   input  logic          wr_sop,
   input  logic          wr_eop,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_req,
   output logic          rd_dval,
   output logic          rd_sop,
   output logic          rd_eop,
   output logic [DW-1:0] rd_data,
   output logic          pkt_avail,
   output logic [AW:0]   pkt_cnt,
   output logic [15:0]   drop_cnt
);

   localparam int unsigned DEPTH = 2**AW;
   localparam int unsigned PW    = AW + 1;
   localparam int unsigned FW    = AW + 2;
   localparam int unsigned IW    = $clog2(MAX_PKT + 1);
   localparam int unsigned MW    = DW + 2;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_PKT  = 2'd1;
   localparam logic [1:0] W_DROP = 2'd2;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_PKT  = 1'b1;

   // input stage
   logic          in_dval_q, in_dval_d;
   logic          in_sop_q,  in_sop_d;
   logic          in_eop_q,  in_eop_d;
   logic [DW-1:0] in_data_q, in_data_d;

   // write side
   logic [1:0]    ws_q, ws_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] start_ptr_q, start_ptr_d;
   logic [PW-1:0] commit_ptr_q, commit_ptr_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [15:0]   tick_q, tick_d;
   logic [15:0]   drop_q, drop_d;
   logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic          pkt_avail_q, pkt_avail_d;

   // read side
   logic [0:0]    rs_q, rs_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          rd_dval_q, rd_dval_d;
   logic [MW-1:0] rd_word_q;

   // combinational helpers
   logic          commit, rd_done, rd_en, mem_we, fits;
   logic [1:0]    drop_inc;
   logic [AW-1:0] mem_waddr;
   logic [PW-1:0] sop_base, used;
   logic [IW-1:0] word_idx;
   logic [DW-1:0] wr_word_data;
   logic [16:0]   drop_sum;

   logic [MW-1:0] mem [DEPTH];

   // wr_sel gates framing so a deselected channel can never open or close a packet
   always_comb begin
      in_dval_d = wr_sel & wr_dval;
      in_sop_d  = wr_sel & wr_dval & wr_sop;
      in_eop_d  = wr_sel & wr_dval & wr_eop;
      in_data_d = wr_data;
   end

   // sequence tick and tick insertion into the header word
   always_comb begin
      tick_d   = in_sop_q ? tick_q + 16'd1 : tick_q;
      word_idx = in_sop_q ? '0 : idx_q;
      if ((TICK_EN != 0) && (32'(word_idx) == TICK_POS)) begin
         wr_word_data = DW'(tick_d);
      end else begin
         wr_word_data = in_data_q;
      end
   end

   // write FSM: a sop always restarts from the last committed boundary
   always_comb begin
      ws_d         = ws_q;
      wr_ptr_d     = wr_ptr_q;
      start_ptr_d  = start_ptr_q;
      commit_ptr_d = commit_ptr_q;
      idx_d        = idx_q;
      commit       = 1'b0;
      drop_inc     = 2'd0;
      mem_we       = 1'b0;
      mem_waddr    = wr_ptr_q[AW-1:0];
      sop_base     = (ws_q == W_PKT) ? start_ptr_q : wr_ptr_q;
      used         = sop_base - rd_ptr_q;
      fits         = (FW'(DEPTH) - FW'(used)) >= FW'(MAX_PKT);
      if (in_dval_q) begin
         if (in_sop_q) begin
            if (ws_q == W_PKT) begin
               drop_inc = 2'd1;
            end
            if (fits && (in_eop_q || (MAX_PKT > 1))) begin
               mem_we      = 1'b1;
               mem_waddr   = sop_base[AW-1:0];
               start_ptr_d = sop_base;
               wr_ptr_d    = sop_base + PW'(1);
               idx_d       = IW'(1);
               if (in_eop_q) begin
                  commit_ptr_d = sop_base + PW'(1);
                  commit       = 1'b1;
                  ws_d         = W_IDLE;
               end else begin
                  ws_d = W_PKT;
               end
            end else begin
               wr_ptr_d = sop_base;
               drop_inc = drop_inc + 2'd1;
               ws_d     = W_DROP;
            end
         end else begin
            case (ws_q)
               W_PKT: begin
                  if (in_eop_q) begin
                     mem_we       = 1'b1;
                     wr_ptr_d     = wr_ptr_q + PW'(1);
                     commit_ptr_d = wr_ptr_q + PW'(1);
                     commit       = 1'b1;
                     ws_d         = W_IDLE;
                  end else if (32'(idx_q) == MAX_PKT - 1) begin
                     // a non-eop word in the last allowed slot means over-length
                     wr_ptr_d = start_ptr_q;
                     drop_inc = 2'd1;
                     ws_d     = W_DROP;
                  end else begin
                     mem_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + PW'(1);
                     idx_d    = idx_q + IW'(1);
                  end
               end
               W_DROP: begin
                  if (in_eop_q) begin
                     ws_d = W_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // read FSM: the eop flag is known only once the word reaches the output
   // register, so packet end is detected one cycle after the eop read
   always_comb begin
      rs_d     = rs_q;
      rd_ptr_d = rd_ptr_q;
      rd_en    = 1'b0;
      rd_done  = 1'b0;
      case (rs_q)
         R_IDLE: begin
            if (rd_req && (pkt_cnt_q != '0) && (rd_ptr_q != commit_ptr_q)) begin
               rd_en    = 1'b1;
               rd_ptr_d = rd_ptr_q + PW'(1);
               rs_d     = R_PKT;
            end
         end
         default: begin
            if (rd_dval_q && rd_word_q[MW-2]) begin
               rd_done = 1'b1;
               rs_d    = R_IDLE;
            end else if (rd_req && (rd_ptr_q != commit_ptr_q)) begin
               rd_en    = 1'b1;
               rd_ptr_d = rd_ptr_q + PW'(1);
            end
         end
      endcase
      rd_dval_d = rd_en;
   end

   // counters
   always_comb begin
      pkt_cnt_d   = pkt_cnt_q + PW'(commit) - PW'(rd_done);
      pkt_avail_d = (pkt_cnt_d != '0);
      drop_sum    = 17'(drop_q) + 17'(drop_inc);
      drop_d      = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_ff @(posedge clk_12_5m or posedge rst_12_5m) begin
      if (rst_12_5m) begin
         in_dval_q    <= 1'b0;
         in_sop_q     <= 1'b0;
         in_eop_q     <= 1'b0;
         in_data_q    <= '0;
         ws_q         <= W_IDLE;
         wr_ptr_q     <= '0;
         start_ptr_q  <= '0;
         commit_ptr_q <= '0;
         idx_q        <= '0;
         tick_q       <= '0;
         drop_q       <= '0;
         pkt_cnt_q    <= '0;
         pkt_avail_q  <= 1'b0;
         rs_q         <= R_IDLE;
         rd_ptr_q     <= '0;
         rd_dval_q    <= 1'b0;
      end else begin
         in_dval_q    <= in_dval_d;
         in_sop_q     <= in_sop_d;
         in_eop_q     <= in_eop_d;
         in_data_q    <= in_data_d;
         ws_q         <= ws_d;
         wr_ptr_q     <= wr_ptr_d;
         start_ptr_q  <= start_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         idx_q        <= idx_d;
         tick_q       <= tick_d;
         drop_q       <= drop_d;
         pkt_cnt_q    <= pkt_cnt_d;
         pkt_avail_q  <= pkt_avail_d;
         rs_q         <= rs_d;
         rd_ptr_q     <= rd_ptr_d;
         rd_dval_q    <= rd_dval_d;
      end
   end

   // RAM write port; contents need no reset
   always_ff @(posedge clk_12_5m) begin
      if (mem_we) begin
         mem[mem_waddr] <= {in_sop_q, in_eop_q, wr_word_data};
      end
   end

   // RAM read port doubles as the output register; cleared when no read occurs
   always_ff @(posedge clk_12_5m or posedge rst_12_5m) begin
      if (rst_12_5m) begin
         rd_word_q <= '0;
      end else if (rd_en) begin
         rd_word_q <= mem[rd_ptr_q[AW-1:0]];
      end else begin
         rd_word_q <= '0;
      end
   end

   assign rd_dval   = rd_dval_q;
   assign rd_sop    = rd_word_q[MW-1];
   assign rd_eop    = rd_word_q[MW-2];
   assign rd_data   = rd_word_q[DW-1:0];
   assign pkt_avail = pkt_avail_q;
   assign pkt_cnt   = pkt_cnt_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_io_mmtx_pkt.sv
// tb_io_mmtx_pkt: self-checking bench for io_mmtx_pkt (default parameters).
// Directed table of single packets, hand sequences for multi-packet corners,
// and randomized traffic checked against a packet-level reference model.
`timescale 1ns/1ps
module tb_io_mmtx_pkt;

   localparam int unsigned DW       = 16;
   localparam int unsigned AW       = 10;
   localparam int unsigned DEPTH    = 1024;
   localparam int unsigned MAX_PKT  = 256;
   localparam int unsigned TICK_POS = 1;

   typedef logic [DW+1:0] word_t;

   typedef struct {
      int          len;
      logic [15:0] base;
      int          exp_cnt;
      int          exp_drop;
      int          exp_tick;   // 0 = no tick word expected
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_sel, wr_dval, wr_sop, wr_eop;
   logic [DW-1:0] wr_data;
   logic          rd_req;
   logic          rd_dval, rd_sop, rd_eop;
   logic [DW-1:0] rd_data;
   logic          pkt_avail;
   logic [AW:0]   pkt_cnt;
   logic [15:0]   drop_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   word_t rx_q[$];

   // reference model state
   logic [15:0] m_tick;
   int          m_drop, m_stored, m_pkts;
   bit          m_open;
   word_t       m_cur[$];
   word_t       m_exp[$];

   io_mmtx_pkt dut (
      .clk_12_5m (clk),
      .rst_12_5m (rst),
      .wr_sel    (wr_sel),
      .wr_dval   (wr_dval),
      .wr_sop    (wr_sop),
      .wr_eop    (wr_eop),
      .wr_data   (wr_data),
      .rd_req    (rd_req),
      .rd_dval   (rd_dval),
      .rd_sop    (rd_sop),
      .rd_eop    (rd_eop),
      .rd_data   (rd_data),
      .pkt_avail (pkt_avail),
      .pkt_cnt   (pkt_cnt),
      .drop_cnt  (drop_cnt)
   );

   always #40 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && rd_dval) rx_q.push_back({rd_sop, rd_eop, rd_data});
   end

   initial begin
      #20ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic word_t mk(input bit s, input bit e, input logic [DW-1:0] d);
      return {s, e, d};
   endfunction

   // ---------------- reference model ----------------
   function automatic void m_reset();
      m_tick = '0; m_drop = 0; m_stored = 0; m_pkts = 0; m_open = 0;
      m_cur.delete(); m_exp.delete();
   endfunction

   function automatic void m_commit();
      foreach (m_cur[i]) m_exp.push_back(m_cur[i]);
      m_stored += m_cur.size();
      m_pkts++;
      m_open = 0;
      m_cur.delete();
   endfunction

   function automatic void m_word(input bit sop, input bit eop, input logic [DW-1:0] d);
      logic [DW-1:0] v;
      if (sop) begin
         m_tick++;
         if (m_open) begin
            m_drop++; m_open = 0; m_cur.delete();
         end
         if (int'(DEPTH) - m_stored >= int'(MAX_PKT)) begin
            m_open = 1;
            v = (TICK_POS == 0) ? m_tick : d;
            m_cur.push_back({1'b1, eop, v});
            if (eop) m_commit();
         end else begin
            m_drop++;
         end
      end else if (m_open) begin
         v = (m_cur.size() == int'(TICK_POS)) ? m_tick : d;
         m_cur.push_back({1'b0, eop, v});
         if (eop) m_commit();
         else if (m_cur.size() == int'(MAX_PKT)) begin
            m_drop++; m_open = 0; m_cur.delete();
         end
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic send_word(input bit sel, input bit dv, input bit sop, input bit eop,
                            input logic [DW-1:0] d);
      @(negedge clk);
      wr_sel = sel; wr_dval = dv; wr_sop = sop; wr_eop = eop; wr_data = d;
      if (sel && dv) m_word(sop, eop, d);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         wr_sel = 0; wr_dval = 0; wr_sop = 0; wr_eop = 0;
      end
   endtask

   task automatic send_pkt(input int len, input logic [DW-1:0] base, input bit close);
      for (int i = 0; i < len; i++)
         send_word(1, 1, i == 0, close && (i == len - 1), base + DW'(i));
   endtask

   task automatic do_reset();
      rst = 1; rd_req = 0;
      idle(2);
      rst = 0;
      m_reset();
      rx_q.delete();
   endtask

   task automatic drain(input int n);
      rd_req = 1;
      for (int c = 0; c < 2 * n + 20 && rx_q.size() < n; c++) @(negedge clk);
      repeat (2) @(negedge clk);
      rd_req = 0;
      idle(3);
      chk("drain_word_count", 64'(rx_q.size()), 64'(n));
   endtask

   task automatic model_drain(input string nm);
      int n;
      n = m_exp.size();
      rx_q.delete();
      drain(n);
      for (int i = 0; i < n; i++) chk(nm, 64'(rx_q[i]), 64'(m_exp[i]));
      chk("pkt_cnt_after_drain", 64'(pkt_cnt), 64'(0));
      m_exp.delete(); m_stored = 0; m_pkts = 0;
      rx_q.delete();
   endtask

   task automatic rand_pkt(input int len, input bit close);
      for (int i = 0; i < len; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0)
               send_word(0, 1, 1'($urandom), 1'($urandom), DW'($urandom));
            else
               send_word(1, 0, 1'($urandom), 1'($urandom), DW'($urandom));
         end
         send_word(1, 1, i == 0, close && (i == len - 1), DW'($urandom));
      end
   endtask

   vec_t tbl[8];

   initial begin
      int got, len, r, npk;
      word_t w;

      tbl[0] = '{8,   16'h0100, 1, 0, 1};
      tbl[1] = '{1,   16'h0200, 1, 0, 0};
      tbl[2] = '{2,   16'h0300, 1, 0, 3};
      tbl[3] = '{300, 16'h0400, 0, 1, 0};
      tbl[4] = '{2,   16'h0500, 1, 1, 5};
      tbl[5] = '{256, 16'h0600, 1, 1, 6};
      tbl[6] = '{257, 16'h0700, 0, 2, 0};
      tbl[7] = '{3,   16'h0800, 1, 2, 8};

      rst = 1; rd_req = 0; wr_sel = 0; wr_dval = 0; wr_sop = 0; wr_eop = 0; wr_data = '0;
      m_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset_outputs", {rd_dval, rd_sop, rd_eop, rd_data, pkt_avail, pkt_cnt, drop_cnt}, '0);
      rst = 0;
      idle(2);

      // ---- directed table ----
      for (int t = 0; t < 8; t++) begin
         rx_q.delete();
         send_pkt(tbl[t].len, tbl[t].base, 1);
         idle(1);
         chk("pkt_cnt_before_commit", 64'(pkt_cnt), 64'(0));
         idle(1);
         chk("pkt_cnt_commit_latency", 64'(pkt_cnt), 64'(tbl[t].exp_cnt));
         idle(1);
         chk("pkt_avail", 64'(pkt_avail), 64'(tbl[t].exp_cnt != 0));
         chk("drop_cnt", 64'(drop_cnt), 64'(tbl[t].exp_drop));
         len = (tbl[t].exp_cnt != 0) ? tbl[t].len : 0;
         drain(len);
         for (int i = 0; i < len; i++) begin
            w = mk(i == 0, i == len - 1,
                   (i == 1 && tbl[t].exp_tick != 0) ? 16'(tbl[t].exp_tick) : tbl[t].base + 16'(i));
            chk("table_word", 64'(rx_q[i]), 64'(w));
         end
         chk("pkt_cnt_drained", 64'(pkt_cnt), 64'(0));
         m_exp.delete(); m_stored = 0; m_pkts = 0;
      end

      // ---- three back-to-back packets, read afterwards ----
      do_reset();
      for (int p = 0; p < 3; p++) send_pkt(4, 16'h0A00 + 16'(p * 16), 1);
      idle(3);
      chk("three_pkt_cnt", 64'(pkt_cnt), 64'(3));
      drain(12);
      for (int p = 0; p < 3; p++) begin
         chk("three_sop_word", 64'(rx_q[p*4]),   64'(mk(1, 0, 16'h0A00 + 16'(p * 16))));
         chk("three_tick",     64'(rx_q[p*4+1]), 64'(mk(0, 0, 16'(p + 1))));
         chk("three_eop_word", 64'(rx_q[p*4+3]), 64'(mk(0, 1, 16'h0A03 + 16'(p * 16))));
      end

      // ---- buffer full: fifth max-length packet dropped ----
      do_reset();
      for (int p = 0; p < 5; p++) send_pkt(256, 16'h1000 * 16'(p + 1), 1);
      idle(3);
      chk("full_pkt_cnt", 64'(pkt_cnt), 64'(4));
      chk("full_drop_cnt", 64'(drop_cnt), 64'(1));
      model_drain("full_word");
      send_pkt(4, 16'h0B00, 1);
      idle(3);
      drain(4);
      chk("full_next_tick", 64'(rx_q[1]), 64'(mk(0, 0, 16'd6)));
      chk("full_drop_hold", 64'(drop_cnt), 64'(1));

      // ---- abort by sop, then one-word packet ----
      do_reset();
      send_pkt(5, 16'h0C00, 0);
      send_pkt(6, 16'h0D00, 1);
      idle(3);
      chk("abort_drop_cnt", 64'(drop_cnt), 64'(1));
      chk("abort_pkt_cnt", 64'(pkt_cnt), 64'(1));
      send_word(1, 1, 1, 1, 16'h0E00);
      idle(3);
      chk("one_word_pkt_cnt", 64'(pkt_cnt), 64'(2));
      drain(7);
      chk("abort_b_sop",  64'(rx_q[0]), 64'(mk(1, 0, 16'h0D00)));
      chk("abort_b_tick", 64'(rx_q[1]), 64'(mk(0, 0, 16'd2)));
      chk("abort_b_eop",  64'(rx_q[5]), 64'(mk(0, 1, 16'h0D05)));
      chk("one_word",     64'(rx_q[6]), 64'(mk(1, 1, 16'h0E00)));

      // ---- toggling rd_req, then reset mid-read ----
      do_reset();
      send_pkt(8, 16'h0F00, 1);
      send_pkt(8, 16'h0F80, 1);
      idle(3);
      rx_q.delete();
      for (int c = 0; c < 200 && rx_q.size() < 5; c++) begin
         @(negedge clk);
         rd_req = ~rd_req;
      end
      rst = 1; rd_req = 0;
      got = rx_q.size();
      chk("toggle_words_seen", 64'(got >= 5 && got <= 8), 64'(1));
      for (int i = 0; i < got; i++)
         chk("toggle_word", 64'(rx_q[i]),
             64'(mk(i == 0, i == 7, (i == 1) ? 16'd1 : 16'h0F00 + 16'(i))));
      @(negedge clk);
      chk("midreset_outputs", {rd_dval, rd_sop, rd_eop, rd_data, pkt_avail, pkt_cnt, drop_cnt}, '0);
      @(negedge clk);
      rst = 0;
      m_reset();
      rx_q.delete();
      idle(2);
      chk("post_reset_pkt_cnt", 64'(pkt_cnt), 64'(0));
      send_pkt(3, 16'h0123, 1);
      idle(3);
      drain(3);
      chk("post_reset_tick", 64'(rx_q[1]), 64'(mk(0, 0, 16'd1)));

      // ---- randomized traffic vs reference model ----
      do_reset();
      for (int round = 0; round < 5; round++) begin
         npk = $urandom_range(1, 8);
         for (int p = 0; p < npk; p++) begin
            if ($urandom_range(0, 4) == 0) send_word(1, 1, 0, 1'($urandom), DW'($urandom));
            r = $urandom_range(0, 9);
            if (r < 6)      rand_pkt($urandom_range(1, 20), 1);
            else if (r < 8) rand_pkt($urandom_range(200, 300), 1);
            else            rand_pkt($urandom_range(1, 5), 0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         end
         idle(4);
         chk("rand_pkt_cnt", 64'(pkt_cnt), 64'(m_pkts));
         chk("rand_pkt_avail", 64'(pkt_avail), 64'(m_pkts != 0));
         chk("rand_drop_cnt", 64'(drop_cnt), 64'(m_drop));
         model_drain("rand_word");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/io_mmtx_pkt.md
Name: io_mmtx_pkt

Overview:
- Parametrised store-and-forward packet buffer for the IO channel transmit data path; successor to the fixed 16-bit/1024-deep transmit memory manager.
- Accepts framed words (sop/eop/dval) from the TX SDU and overwrites one header word per packet with a 16-bit packet sequence tick.
- Releases only complete packets to the reader. Packets that cannot fit, are over-length, or are aborted are dropped whole and counted.
- Uses an inferred dual-port RAM with speculative/commit write pointers, not a vendor FIFO.

Parameters:
- DW, 16, data word width (>=16).
- AW, 10, address width; DEPTH = 2**AW words.
- MAX_PKT, 256, maximum packet length in words (<= DEPTH).
- TICK_EN, 1, 1 = insert sequence tick; 0 = pass data unchanged.
- TICK_POS, 1, word index (0 = sop word) replaced by the tick.

Ports:
- clk_12_5m, in, 1, 12.5 MHz clock.
- rst_12_5m, in, 1, asynchronous reset, active-high.
- wr_sel, in, 1, write channel select; all write inputs are ignored when low.
- wr_dval, in, 1, write word valid.
- wr_sop, in, 1, first word of packet (qualified by wr_dval).
- wr_eop, in, 1, last word of packet (qualified by wr_dval).
- wr_data, in, DW, write data.
- rd_req, in, 1, read request (level); one word per cycle while high.
- rd_dval, out, 1, read data valid.
- rd_sop, out, 1, first word of packet on the read port.
- rd_eop, out, 1, last word of packet on the read port.
- rd_data, out, DW, read data.
- pkt_avail, out, 1, at least one complete packet is stored.
- pkt_cnt, out, AW+1, number of complete packets stored.
- drop_cnt, out, 16, dropped-packet count, saturating at 0xFFFF.

Behaviour:
- Reset: all outputs 0. Pointers, FSMs and tick are cleared. RAM contents are don't-care.
- Reset mid-operation: all stored and partial packets are lost; no further output until new packets are committed.
- Input stage: wr_* are registered once and gated by wr_sel, so wr_sel = 0 forces dval/sop/eop = 0.
- Each RAM word stores {sop, eop, data}.
- Tick:
  - 16-bit pkt_tick increments on every registered sop, including sops of dropped packets; wraps 0xFFFF -> 0x0000.
  - The first packet after reset carries 1.
  - When TICK_EN = 1, word TICK_POS of the packet is written as the post-increment tick, zero-extended to DW.
  - Packets shorter than TICK_POS+1 words carry no tick.
- Free space: free = DEPTH - (wr_ptr - rd_ptr), where wr_ptr is the speculative write pointer.
- Write FSM, states W_IDLE, W_PKT, W_DROP:
  - W_IDLE, sop:
    - free >= MAX_PKT: write the word, set start_ptr = wr_ptr, go to W_PKT.
    - otherwise: drop_cnt++, go to W_DROP.
  - W_IDLE, non-sop words: discarded.
  - W_PKT, each dval: write the word, word index++.
  - W_PKT, eop: set commit_ptr = wr_ptr+1, pkt_cnt++, go to W_IDLE.
  - W_PKT, index reaches MAX_PKT without eop: wr_ptr = start_ptr, drop_cnt++, go to W_DROP.
  - W_PKT, sop: wr_ptr = start_ptr, drop_cnt++, then the sop is evaluated as in W_IDLE.
  - W_DROP: discard words until eop, then go to W_IDLE. A sop is evaluated as in W_IDLE.
  - sop and eop on the same word forms a one-word packet and is committed immediately.
- Commit latency: pkt_avail/pkt_cnt update 2 cycles after the cycle wr_eop is presented.
- Read FSM, states R_IDLE, R_PKT:
  - R_IDLE: rd_req and pkt_cnt > 0 -> read RAM[rd_ptr], go to R_PKT.
  - R_PKT: each cycle rd_req is high, read the next word. rd_req low pauses reading with no data loss.
  - When the eop word is read: pkt_cnt--, go to R_IDLE.
  - The reader never passes commit_ptr.
- Read latency: rd_dval/rd_sop/rd_eop/rd_data appear 1 cycle after the read. They are 0 when no read occurred.
- Simultaneous commit and read-eop in one cycle: pkt_cnt unchanged.
- Pointers are AW+1 bits with natural wrap-around.
- Full: the space check at sop guarantees no overwrite.
- drop_cnt saturates at 0xFFFF; pkt_tick is unaffected by saturation.

Test Plan:
- Reset, then one 8-word packet D0..D7, then rd_req held -> rd_sop with D0, word 1 = 0x0001, D2..D7, rd_eop on the 8th word; pkt_cnt 1 -> 0.
- Three back-to-back 4-word packets, rd_req low until all are written -> pkt_cnt = 3. Draining yields ticks 1, 2, 3 with packet order preserved.
- DEPTH = 1024, MAX_PKT = 256. Write four 256-word packets without reading, then a fifth -> fifth dropped, drop_cnt = 1. The next stored packet carries tick 6.
- 300-word packet with MAX_PKT = 256 -> nothing readable, drop_cnt = 1. A following 2-word packet reads out correctly with tick 2.
- Sop at word 5 of an open packet -> first packet discarded, drop_cnt = 1, second packet is stored intact. A single-word sop+eop packet is readable, with the rd_sop and rd_eop flags both set.
- rd_req toggled every cycle mid-packet, plus an assertion of rst_12_5m mid-read -> no words duplicated or skipped before reset; after reset all outputs are 0, pkt_cnt = 0, and the tick restarts at 1.
